// File: rtl/satswarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : satswarm_pkg
// Brief    : Shared types for the SAT solver: assignment/FSM enums and records.
// Revision : 1.0 - initial release
// ============================================================================
package satswarm_pkg;

    localparam int c_VAR_W = 16;

    typedef enum logic [1:0] {
        ASG_UNASSIGNED = 2'd0,
        ASG_TRUE       = 2'd1,
        ASG_FALSE      = 2'd2
    } assign_e;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_DECIDE    = 3'd2,
        ST_BACKTRACK = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    typedef struct packed {
        logic               sign;
        logic [c_VAR_W-1:0] var_idx;
        logic               clause_end;
    } lit_rec_t;

    typedef struct packed {
        logic [c_VAR_W-1:0] var_idx;
        assign_e            value;
        logic               decision;
    } trail_ent_t;

    // Value that makes a literal TRUE: negative literals need the variable FALSE.
    function automatic assign_e lit_value(input logic sign);
        return sign ? ASG_FALSE : ASG_TRUE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/satswarm_core.sv
`default_nettype none
// ============================================================================
// Module   : satswarm_core
// Brief    : Single DPLL engine: literal store, clause scan, trail and control.
//            Optional SATSWARM_LOAD_CHECK_EN latches load errors.
// Revision : 1.0 - initial release
// ============================================================================
module satswarm_core
    import satswarm_pkg::*;
#(
    parameter int MAX_VARS_PER_CORE    = 128,
    parameter int MAX_CLAUSES_PER_CORE = 128,
    parameter int MAX_LITS             = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load_valid,
    input  logic [31:0] i_load_literal,
    input  logic        i_load_clause_end,
    output logic        o_load_ready,
    input  logic        i_start,
    output logic        o_done,
    output logic        o_sat,
    output logic        o_unsat
);
    localparam int c_IDX_W  = $clog2(MAX_VARS_PER_CORE + 1);
    localparam int c_LIT_W  = $clog2(MAX_LITS + 1);
    localparam int c_LIT_AW = $clog2(MAX_LITS);
    localparam int c_CLS_W  = $clog2(MAX_CLAUSES_PER_CORE + 1);
    localparam int c_TRL_W  = $clog2(MAX_VARS_PER_CORE + 1);
    localparam int c_TRL_AW = $clog2(MAX_VARS_PER_CORE);

    state_e             r_state, w_next_state;
    lit_rec_t           r_lit_mem [MAX_LITS];
    logic [c_LIT_W-1:0] r_lit_cnt, r_scan_idx;
    logic [c_CLS_W-1:0] r_cls_cnt;
    logic [c_IDX_W-1:0] r_num_vars;
    assign_e            r_assign [MAX_VARS_PER_CORE+1];
    trail_ent_t         r_trail [MAX_VARS_PER_CORE];
    logic [c_TRL_W-1:0] r_trail_cnt;
    logic               r_any_true, r_implied, r_sat, r_unsat;
    logic [1:0]         r_ucnt;
    lit_rec_t           r_last;

    logic [31:0] w_mag;
    logic        w_in_range, w_ready, w_store, w_err;

    assign w_mag      = i_load_literal[31] ? (~i_load_literal + 32'd1) : i_load_literal;
    assign w_in_range = (w_mag != 32'd0) && (w_mag <= 32'(MAX_VARS_PER_CORE));
    assign w_ready    = (r_state == ST_LOAD) && (r_lit_cnt < c_LIT_W'(MAX_LITS))
                        && (r_cls_cnt < c_CLS_W'(MAX_CLAUSES_PER_CORE));
    assign w_store    = w_ready && i_load_valid && w_in_range;

    // Per-literal scan evaluation against the current assignment
    lit_rec_t   w_cur, w_last;
    assign_e    w_cur_asg;
    logic       w_cur_true, w_cur_unasg, w_pass_end, w_any_true, w_conflict, w_imply;
    logic [1:0] w_ucnt;

    assign w_cur       = r_lit_mem[r_scan_idx[c_LIT_AW-1:0]];
    assign w_cur_asg   = r_assign[w_cur.var_idx[c_IDX_W-1:0]];
    assign w_cur_unasg = (w_cur_asg == ASG_UNASSIGNED);
    assign w_cur_true  = !w_cur_unasg && (w_cur_asg == lit_value(w_cur.sign));
    assign w_pass_end  = (r_scan_idx >= r_lit_cnt);
    assign w_any_true  = r_any_true | w_cur_true;
    assign w_ucnt      = (r_ucnt == 2'd2) ? 2'd2 : r_ucnt + {1'b0, w_cur_unasg};
    assign w_last      = w_cur_unasg ? w_cur : r_last;
    assign w_conflict  = !w_pass_end && w_cur.clause_end && !w_any_true && (w_ucnt == 2'd0);
    assign w_imply     = !w_pass_end && w_cur.clause_end && !w_any_true && (w_ucnt == 2'd1);

    logic [MAX_VARS_PER_CORE:1] w_unasg_vec;
    logic                       w_dec_found;
    logic [c_IDX_W-1:0]         w_dec_var;

    for (genvar g = 1; g <= MAX_VARS_PER_CORE; g++) begin : g_unasg
        assign w_unasg_vec[g] = (r_assign[g] == ASG_UNASSIGNED) && (c_IDX_W'(g) <= r_num_vars);
    end

    // Descending sweep so the lowest unassigned index wins
    always_comb begin
        w_dec_found = 1'b0;
        w_dec_var   = '0;
        for (int v = MAX_VARS_PER_CORE; v >= 1; v--) begin
            if (w_unasg_vec[v]) begin
                w_dec_found = 1'b1;
                w_dec_var   = c_IDX_W'(v);
            end
        end
    end

    logic [c_TRL_W-1:0] w_top_idx;
    trail_ent_t         w_top;
    logic               w_core_unused;

    assign w_top_idx     = r_trail_cnt - c_TRL_W'(1);
    assign w_top         = r_trail[w_top_idx[c_TRL_AW-1:0]];
    assign w_core_unused = ^{w_top, w_top_idx};

`ifdef SATSWARM_LOAD_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_LOAD) && i_load_valid
                     && (!w_ready || ((w_mag != 32'd0) && !w_in_range))) begin
            r_err <= 1'b1;
        end
    end
    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD:      if (i_start) w_next_state = w_err ? ST_DONE : ST_SCAN;
            ST_SCAN: begin
                if (w_pass_end)      w_next_state = r_implied ? ST_SCAN : ST_DECIDE;
                else if (w_conflict) w_next_state = ST_BACKTRACK;
            end
            ST_DECIDE:    w_next_state = w_dec_found ? ST_SCAN : ST_DONE;
            ST_BACKTRACK: begin
                if (r_trail_cnt == '0)  w_next_state = ST_DONE;
                else if (w_top.decision) w_next_state = ST_SCAN;
            end
            default:      w_next_state = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_lit_mem[r_lit_cnt[c_LIT_AW-1:0]] <= '{sign: i_load_literal[31],
                                                   var_idx: c_VAR_W'(w_mag),
                                                   clause_end: i_load_clause_end};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lit_cnt   <= '0;
            r_cls_cnt   <= '0;
            r_num_vars  <= '0;
            r_assign    <= '{default: ASG_UNASSIGNED};
            r_trail     <= '{default: '0};
            r_trail_cnt <= '0;
            r_scan_idx  <= '0;
            r_any_true  <= 1'b0;
            r_ucnt      <= 2'd0;
            r_last      <= '0;
            r_implied   <= 1'b0;
            r_sat       <= 1'b0;
            r_unsat     <= 1'b0;
        end else begin
            // Every non-scan state hands SCAN a fresh pass
            if (r_state != ST_SCAN) begin
                r_scan_idx <= '0;
                r_any_true <= 1'b0;
                r_ucnt     <= 2'd0;
                r_implied  <= 1'b0;
            end
            case (r_state)
                ST_LOAD: begin
                    if (w_store) begin
                        r_lit_cnt <= r_lit_cnt + c_LIT_W'(1);
                        r_cls_cnt <= r_cls_cnt + c_CLS_W'(i_load_clause_end);
                        if (w_mag[c_IDX_W-1:0] > r_num_vars) r_num_vars <= w_mag[c_IDX_W-1:0];
                    end
                end
                ST_SCAN: begin
                    if (w_pass_end) begin
                        r_scan_idx <= '0;
                        r_any_true <= 1'b0;
                        r_ucnt     <= 2'd0;
                        r_implied  <= 1'b0;
                    end else if (!w_conflict) begin
                        r_scan_idx <= r_scan_idx + c_LIT_W'(1);
                        if (w_cur.clause_end) begin
                            r_any_true <= 1'b0;
                            r_ucnt     <= 2'd0;
                            if (w_imply) begin
                                r_assign[w_last.var_idx[c_IDX_W-1:0]]  <= lit_value(w_last.sign);
                                r_trail[r_trail_cnt[c_TRL_AW-1:0]] <= '{var_idx: w_last.var_idx,
                                                                        value: lit_value(w_last.sign),
                                                                        decision: 1'b0};
                                r_trail_cnt <= r_trail_cnt + c_TRL_W'(1);
                                r_implied   <= 1'b1;
                            end
                        end else begin
                            r_any_true <= w_any_true;
                            r_ucnt     <= w_ucnt;
                            r_last     <= w_last;
                        end
                    end
                end
                ST_DECIDE: begin
                    if (w_dec_found) begin
                        r_assign[w_dec_var] <= ASG_FALSE;
                        r_trail[r_trail_cnt[c_TRL_AW-1:0]] <= '{var_idx: c_VAR_W'(w_dec_var),
                                                                value: ASG_FALSE,
                                                                decision: 1'b1};
                        r_trail_cnt <= r_trail_cnt + c_TRL_W'(1);
                    end else begin
                        r_sat <= 1'b1;
                    end
                end
                ST_BACKTRACK: begin
                    if (r_trail_cnt == '0) begin
                        r_unsat <= 1'b1;
                    end else if (!w_top.decision) begin
                        r_assign[w_top.var_idx[c_IDX_W-1:0]] <= ASG_UNASSIGNED;
                        r_trail_cnt <= w_top_idx;
                    end else begin
                        // Flipped decision becomes an implication of the conflict
                        r_assign[w_top.var_idx[c_IDX_W-1:0]] <= ASG_TRUE;
                        r_trail[w_top_idx[c_TRL_AW-1:0]] <= '{var_idx: w_top.var_idx,
                                                              value: ASG_TRUE,
                                                              decision: 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_load_ready = w_ready;
    assign o_done       = (r_state == ST_DONE);
    assign o_sat        = r_sat;
    assign o_unsat      = r_unsat;

endmodule
`default_nettype wire

// File: rtl/satswarm_top.sv
`default_nettype none
// ============================================================================
// Module   : satswarm_top
// Brief    : SAT solver top: one satswarm_core engine, external-memory port idle.
//            Define SATSWARM_LOAD_CHECK_EN to enable load error detection.
// Revision : 1.0 - initial release
// ============================================================================
module satswarm_top #(
    parameter int GRID_X               = 2,
    parameter int GRID_Y               = 2,
    parameter int MAX_VARS_PER_CORE    = 128,
    parameter int MAX_CLAUSES_PER_CORE = 128,
    parameter int MAX_LITS             = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_load_valid,
    input  logic [31:0] host_load_literal,
    input  logic        host_load_clause_end,
    output logic        host_load_ready,
    input  logic        host_start,
    output logic        host_done,
    output logic        host_sat,
    output logic        host_unsat,
    output logic        ddr_read_req,
    output logic [31:0] ddr_read_addr,
    output logic [7:0]  ddr_read_len,
    input  logic        ddr_read_grant,
    input  logic [31:0] ddr_read_data,
    input  logic        ddr_read_valid,
    output logic        ddr_write_req,
    output logic [31:0] ddr_write_addr,
    output logic [31:0] ddr_write_data,
    input  logic        ddr_write_grant
);
    // Grid dimensions are validated only; a single engine serves the whole grid
    if (GRID_X < 1 || GRID_Y < 1) begin : g_grid_check
        $error("satswarm_top: GRID_X and GRID_Y must be >= 1");
    end

    satswarm_core #(
        .MAX_VARS_PER_CORE    (MAX_VARS_PER_CORE),
        .MAX_CLAUSES_PER_CORE (MAX_CLAUSES_PER_CORE),
        .MAX_LITS             (MAX_LITS)
    ) u_core (
        .clk               (clk),
        .rst               (rst_n),
        .i_load_valid      (host_load_valid),
        .i_load_literal    (host_load_literal),
        .i_load_clause_end (host_load_clause_end),
        .o_load_ready      (host_load_ready),
        .i_start           (host_start),
        .o_done            (host_done),
        .o_sat             (host_sat),
        .o_unsat           (host_unsat)
    );

    assign ddr_read_req   = 1'b0;
    assign ddr_read_addr  = 32'd0;
    assign ddr_read_len   = 8'd0;
    assign ddr_write_req  = 1'b0;
    assign ddr_write_addr = 32'd0;
    assign ddr_write_data = 32'd0;

    logic w_ddr_unused;
    assign w_ddr_unused = ^{ddr_read_grant, ddr_read_data, ddr_read_valid, ddr_write_grant};

endmodule
`default_nettype wire

// File: tb/tb_satswarm_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_satswarm_top
// Brief    : Self-checking bench for satswarm_top with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_satswarm_top;
    import satswarm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_load_valid, host_load_clause_end, host_load_ready, host_start;
    logic [31:0] host_load_literal;
    logic        host_done, host_sat, host_unsat;
    logic        ddr_read_req, ddr_write_req;
    logic [31:0] ddr_read_addr, ddr_write_addr, ddr_write_data;
    logic [7:0]  ddr_read_len;

    always #5 clk = ~clk;

    satswarm_top #(
        .GRID_X(2), .GRID_Y(2), .MAX_VARS_PER_CORE(128),
        .MAX_CLAUSES_PER_CORE(128), .MAX_LITS(512)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_load_valid(host_load_valid), .host_load_literal(host_load_literal),
        .host_load_clause_end(host_load_clause_end), .host_load_ready(host_load_ready),
        .host_start(host_start), .host_done(host_done), .host_sat(host_sat),
        .host_unsat(host_unsat),
        .ddr_read_req(ddr_read_req), .ddr_read_addr(ddr_read_addr), .ddr_read_len(ddr_read_len),
        .ddr_read_grant(1'b0), .ddr_read_data(32'hDEAD_BEEF), .ddr_read_valid(1'b1),
        .ddr_write_req(ddr_write_req), .ddr_write_addr(ddr_write_addr),
        .ddr_write_data(ddr_write_data), .ddr_write_grant(1'b1)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q [$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_lit(input int lit, input logic last);
        int guard = 0;
        host_load_valid      = 1'b1;
        host_load_literal    = 32'(lit);
        host_load_clause_end = last;
        while (!host_load_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!host_load_ready) chk_val("send.ready", 32'(host_load_ready), 32'd1);
        @(negedge clk);
        host_load_valid = 1'b0;
    endtask

    task automatic run_solve(input string tag, input logic exp_sat, input logic exp_unsat);
        logic [1:0] e;
        int         cyc = 0;
        exp_q.push_back({exp_sat, exp_unsat});
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        while (!host_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk_val({tag, ".done"}, 32'(host_done), 32'd1);
        e = exp_q.pop_front();
        chk_val({tag, ".sat"},   32'(host_sat),   32'(e[1]));
        chk_val({tag, ".unsat"}, 32'(host_unsat), 32'(e[0]));
    endtask

    initial begin
        int acc;
        host_load_valid      = 1'b0;
        host_load_literal    = '0;
        host_load_clause_end = 1'b0;
        host_start           = 1'b0;
        apply_reset();

        chk_val("rst.ready", 32'(host_load_ready), 32'd1);
        chk_val("rst.done",  32'(host_done),  32'd0);
        chk_val("rst.sat",   32'(host_sat),   32'd0);
        chk_val("rst.unsat", 32'(host_unsat), 32'd0);
        chk_val("rst.ddr", 32'(|{ddr_read_req, ddr_read_addr, ddr_read_len, ddr_write_req,
                                  ddr_write_addr, ddr_write_data}), 32'd0);

        // (1)(-1): contradiction
        send_lit(1, 1'b1);
        send_lit(-1, 1'b1);
        run_solve("unit_conflict", 1'b0, 1'b1);
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("hold.done",  32'(host_done),  32'd1);
        chk_val("hold.unsat", 32'(host_unsat), 32'd1);
        chk_val("hold.sat",   32'(host_sat),   32'd0);

        // (1 2)(-1): forced var1=F, var2=T
        apply_reset();
        send_lit(1, 1'b0);
        send_lit(2, 1'b1);
        send_lit(-1, 1'b1);
        run_solve("two_clause", 1'b1, 1'b0);
        chk_val("two_clause.v1", 32'(dut.u_core.r_assign[1]), 32'(ASG_FALSE));
        chk_val("two_clause.v2", 32'(dut.u_core.r_assign[2]), 32'(ASG_TRUE));

        apply_reset();
        run_solve("empty", 1'b1, 1'b0);

        // All 8 sign combinations over vars 1..3
        apply_reset();
        for (int m = 0; m < 8; m++) begin
            for (int i = 0; i < 3; i++) begin
                send_lit(((m >> i) & 1) != 0 ? -(i + 1) : (i + 1), i == 2);
            end
        end
        run_solve("all8", 1'b0, 1'b1);

        // (1 2)(1 -2): first decision fails, flip needed
        apply_reset();
        send_lit(1, 1'b0);
        send_lit(2, 1'b1);
        send_lit(1, 1'b0);
        send_lit(-2, 1'b1);
        run_solve("flip", 1'b1, 1'b0);
        chk_val("flip.v1", 32'(dut.u_core.r_assign[1]), 32'(ASG_TRUE));

        // Offer MAX_LITS+1 beats
        apply_reset();
        acc = 0;
        host_load_valid      = 1'b1;
        host_load_literal    = 32'd1;
        host_load_clause_end = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!host_load_ready) break;
            acc++;
            @(negedge clk);
        end
        chk_val("full.accepted", 32'(acc), 32'd512);
        chk_val("full.ready", 32'(host_load_ready), 32'd0);
        host_load_valid = 1'b0;

        // Reset in the middle of a long scan
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        chk_val("solve.ready", 32'(host_load_ready), 32'd0);
        repeat (20) @(negedge clk);
        chk_val("midscan.done", 32'(host_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("inrst.done",  32'(host_done),  32'd0);
        chk_val("inrst.sat",   32'(host_sat),   32'd0);
        chk_val("inrst.unsat", 32'(host_unsat), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_val("postrst.ready", 32'(host_load_ready), 32'd1);
        send_lit(1, 1'b1);
        run_solve("reload", 1'b1, 1'b0);
        chk_val("reload.v1", 32'(dut.u_core.r_assign[1]), 32'(ASG_TRUE));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
